// File: rtl/apb_completer_regs.sv
// APB4 completer fronting a bank of NUM_REGS memory-mapped registers with optional wait states,
// byte strobes, read-only registers and error response. Define APB_PARITY_EN for APB5 odd-parity checking.
module apb_completer_regs #(
   parameter int                  ADDR_WIDTH  = 12,
   parameter int                  DATA_WIDTH  = 32,
   parameter int                  NUM_REGS    = 16,
   parameter int                  WAIT_STATES = 0,
   parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
   input  logic                           PCLK,
   input  logic                           PRESETn,
   input  logic [ADDR_WIDTH-1:0]          PADDR,
   input  logic [2:0]                     PPROT,
   input  logic                           PSEL,
   input  logic                           PENABLE,
   input  logic                           PWRITE,
   input  logic [DATA_WIDTH-1:0]          PWDATA,
   input  logic [DATA_WIDTH/8-1:0]        PSTRB,
   output logic                           PREADY,
   output logic [DATA_WIDTH-1:0]          PRDATA,
   output logic                           PSLVERR,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_in,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
`ifdef APB_PARITY_EN
   input  logic [(ADDR_WIDTH+7)/8-1:0]    PADDRCHK,
   input  logic [DATA_WIDTH/8-1:0]        PWDATACHK,
   output logic [DATA_WIDTH/8-1:0]        PRDATACHK,
   output logic                           PREADYCHK,
   output logic                           PSLVERRCHK,
   output logic                           parity_err,
`endif
   output logic [0:0]                     dbg_state
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int BO = $clog2(NB);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACCESS = 1'b1;

   logic [0:0]                     state_q, state_d;
   logic [3:0]                     cnt_q, cnt_d;
   logic                           pready_q, pready_d;
   logic [DATA_WIDTH-1:0]          prdata_q, prdata_d;
   logic                           pslverr_q, pslverr_d;
   logic                           perr_q, perr_d;
   logic                           aperr_q, aperr_d;
   logic [NUM_REGS*DATA_WIDTH-1:0] regs_q, regs_d;

   logic [31:0]           idx;
   logic                  in_range;
   logic                  is_ro;
   logic [DATA_WIDTH-1:0] rd_val;
   logic                  addr_perr_c;
   logic                  data_perr_c;
   logic                  par_now;
   logic                  resp_err;
   logic [DATA_WIDTH-1:0] resp_data;
   logic                  unused_ok;

   always_comb begin
      idx      = 32'(PADDR) >> BO;
      in_range = (idx < 32'(NUM_REGS));
      is_ro    = 1'b0;
      rd_val   = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (idx == 32'(i)) begin
            is_ro  = RO_MASK[i];
            rd_val = RO_MASK[i] ? ro_in[i*DATA_WIDTH +: DATA_WIDTH]
                                : regs_q[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

`ifdef APB_PARITY_EN
   localparam int AB  = (ADDR_WIDTH + 7) / 8;
   localparam int APW = AB * 8;

   logic [APW-1:0] paddr_pad;
   assign paddr_pad = APW'(PADDR);

   // Odd parity: a byte plus its check bit must hold an odd number of ones.
   always_comb begin
      addr_perr_c = 1'b0;
      data_perr_c = 1'b0;
      for (int k = 0; k < AB; k++) begin
         if (^{PADDRCHK[k], paddr_pad[k*8 +: 8]} == 1'b0) addr_perr_c = 1'b1;
      end
      for (int k = 0; k < NB; k++) begin
         if (^{PWDATACHK[k], PWDATA[k*8 +: 8]} == 1'b0) data_perr_c = 1'b1;
      end
   end

   always_comb begin
      PRDATACHK = '0;
      for (int k = 0; k < NB; k++) PRDATACHK[k] = ~^prdata_q[k*8 +: 8];
   end

   assign PREADYCHK  = ~pready_q;
   assign PSLVERRCHK = ~pslverr_q;
   assign parity_err = perr_q;
`else
   assign addr_perr_c = 1'b0;
   assign data_perr_c = 1'b0;
`endif

   // Address parity is only sampled in the setup cycle, so later decisions use the latched flag.
   assign par_now   = ((state_q == ST_IDLE) ? addr_perr_c : aperr_q) | (PWRITE & data_perr_c);
   assign resp_err  = ~in_range | (PWRITE & is_ro) | par_now;
   assign resp_data = (!PWRITE && !resp_err) ? rd_val : '0;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pready_d  = 1'b0;
      prdata_d  = '0;
      pslverr_d = 1'b0;
      perr_d    = 1'b0;
      aperr_d   = aperr_q;
      regs_d    = regs_q;
      case (state_q)
         ST_IDLE: begin
            if (PSEL && !PENABLE) begin
               state_d = ST_ACCESS;
               cnt_d   = 4'(WAIT_STATES);
               aperr_d = addr_perr_c;
               if (WAIT_STATES == 0) begin
                  pready_d  = 1'b1;
                  prdata_d  = resp_data;
                  pslverr_d = resp_err;
                  perr_d    = par_now;
               end
            end
         end
         ST_ACCESS: begin
            if (!(PSEL && PENABLE)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               aperr_d = 1'b0;
            end else if (!pready_q) begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  pready_d  = 1'b1;
                  prdata_d  = resp_data;
                  pslverr_d = resp_err;
                  perr_d    = par_now;
               end
            end else begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               aperr_d = 1'b0;
               // The registered error already covers range, read-only and parity failures.
               if (PWRITE && !pslverr_q && in_range && !is_ro) begin
                  for (int i = 0; i < NUM_REGS; i++) begin
                     for (int k = 0; k < NB; k++) begin
                        if (idx == 32'(i) && PSTRB[k])
                           regs_d[i*DATA_WIDTH + k*8 +: 8] = PWDATA[k*8 +: 8];
                     end
                  end
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         pready_q  <= 1'b0;
         prdata_q  <= '0;
         pslverr_q <= 1'b0;
         perr_q    <= 1'b0;
         aperr_q   <= 1'b0;
         regs_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pready_q  <= pready_d;
         prdata_q  <= prdata_d;
         pslverr_q <= pslverr_d;
         perr_q    <= perr_d;
         aperr_q   <= aperr_d;
         regs_q    <= regs_d;
      end
   end

   assign PREADY    = pready_q;
   assign PRDATA    = prdata_q;
   assign PSLVERR   = pslverr_q;
   assign reg_out   = regs_q;
   assign dbg_state = state_q;
   assign unused_ok = ^{PPROT, perr_q};

endmodule

// File: tb/tb_apb_completer_regs.sv
// Bench for apb_completer_regs: two completers on one APB bus (no wait states / three wait states with a
// read-only register), table-driven transfers checked through an expected queue, plus hand-written corner cases.
module tb_apb_completer_regs;

   localparam int AW = 12;
   localparam int DW = 32;
   localparam int NR = 16;

   logic           PCLK = 1'b0;
   logic           PRESETn;
   logic [AW-1:0]  PADDR;
   logic [2:0]     PPROT;
   logic           psel0, psel1;
   logic           PENABLE;
   logic           PWRITE;
   logic [DW-1:0]  PWDATA;
   logic [DW/8-1:0] PSTRB;
   logic           pready0, pready1;
   logic [DW-1:0]  prdata0, prdata1;
   logic           pslverr0, pslverr1;
   logic [NR*DW-1:0] ro_in0, ro_in1;
   logic [NR*DW-1:0] reg_out0, reg_out1;
   logic [0:0]     dbg0, dbg1;

`ifdef APB_PARITY_EN
   logic [1:0] paddrchk;
   logic [3:0] pwdatachk;
   logic       flip_wchk;
   logic [3:0] prdatachk0, prdatachk1;
   logic       preadychk0, preadychk1;
   logic       pslverrchk0, pslverrchk1;
   logic       parity_err0, parity_err1;

   always_comb begin
      paddrchk = {~^PADDR[11:8], ~^PADDR[7:0]};
      for (int k = 0; k < 4; k++) pwdatachk[k] = ~^PWDATA[k*8 +: 8];
      if (flip_wchk) pwdatachk[0] = ~pwdatachk[0];
   end
`endif

   always #5 PCLK = ~PCLK;

   apb_completer_regs #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .WAIT_STATES(0), .RO_MASK(16'h0000)
   ) u_dut0 (
      .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PPROT(PPROT), .PSEL(psel0),
      .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
      .PREADY(pready0), .PRDATA(prdata0), .PSLVERR(pslverr0),
      .ro_in(ro_in0), .reg_out(reg_out0),
`ifdef APB_PARITY_EN
      .PADDRCHK(paddrchk), .PWDATACHK(pwdatachk), .PRDATACHK(prdatachk0),
      .PREADYCHK(preadychk0), .PSLVERRCHK(pslverrchk0), .parity_err(parity_err0),
`endif
      .dbg_state(dbg0)
   );

   apb_completer_regs #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .WAIT_STATES(3), .RO_MASK(16'h0002)
   ) u_dut1 (
      .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PPROT(PPROT), .PSEL(psel1),
      .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
      .PREADY(pready1), .PRDATA(prdata1), .PSLVERR(pslverr1),
      .ro_in(ro_in1), .reg_out(reg_out1),
`ifdef APB_PARITY_EN
      .PADDRCHK(paddrchk), .PWDATACHK(pwdatachk), .PRDATACHK(prdatachk1),
      .PREADYCHK(preadychk1), .PSLVERRCHK(pslverrchk1), .parity_err(parity_err1),
`endif
      .dbg_state(dbg1)
   );

   typedef struct {
      int          dev;
      logic        wr;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t        vecs[$];
   logic [32:0] exp_q[$];
   logic [31:0] m0[NR];
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic step();
      @(posedge PCLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic rdy(input int dev);
      return (dev == 0) ? pready0 : pready1;
   endfunction

   function automatic logic [31:0] rdata(input int dev);
      return (dev == 0) ? prdata0 : prdata1;
   endfunction

   function automatic logic serr(input int dev);
      return (dev == 0) ? pslverr0 : pslverr1;
   endfunction

   // Drives one full transfer; the expected response is queued at setup and retired when PREADY rises.
   task automatic apb_xfer(input int dev, input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic [31:0] exp_rd, input logic exp_err);
      int          waits;
      logic [32:0] exp_v;
      exp_q.push_back({exp_err, exp_rd});
      psel0   = (dev == 0);
      psel1   = (dev == 1);
      PENABLE = 1'b0;
      PWRITE  = wr;
      PADDR   = addr;
      PWDATA  = wdata;
      PSTRB   = strb;
      PPROT   = 3'($urandom_range(0, 7));
      step();
      PENABLE = 1'b1;
      waits   = 0;
      while (!rdy(dev) && waits < 40) begin
         chk("wait_prdata", 64'(rdata(dev)), 64'd0);
         step();
         waits++;
      end
      chk("latency", 64'(waits), 64'((dev == 0) ? 0 : 3));
      exp_v = exp_q.pop_front();
      chk("prdata", 64'(rdata(dev)), 64'(exp_v[31:0]));
      chk("pslverr", 64'(serr(dev)), 64'(exp_v[32]));
      step();
      psel0   = 1'b0;
      psel1   = 1'b0;
      PENABLE = 1'b0;
      chk("ready_drop", 64'(rdy(dev)), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int          ridx;
      logic [31:0] rd;
      logic [3:0]  rs;

      PRESETn = 1'b0;
      PADDR   = '0;
      PPROT   = '0;
      psel0   = 1'b0;
      psel1   = 1'b0;
      PENABLE = 1'b0;
      PWRITE  = 1'b0;
      PWDATA  = '0;
      PSTRB   = '0;
`ifdef APB_PARITY_EN
      flip_wchk = 1'b0;
`endif
      for (int i = 0; i < NR; i++) begin
         ro_in0[i*DW +: DW] = $urandom;
         ro_in1[i*DW +: DW] = 32'hA000_0000 | 32'(i);
      end

      repeat (3) @(posedge PCLK);
      #1;
      chk("rst_pready0", 64'(pready0), 64'd0);
      chk("rst_prdata0", 64'(prdata0), 64'd0);
      chk("rst_pslverr0", 64'(pslverr0), 64'd0);
      chk("rst_regout0", 64'(|reg_out0), 64'd0);
      chk("rst_pready1", 64'(pready1), 64'd0);
      chk("rst_regout1", 64'(|reg_out1), 64'd0);
      chk("rst_state0", 64'(dbg0), 64'd0);
`ifdef APB_PARITY_EN
      chk("rst_prdatachk", 64'(prdatachk0), 64'hF);
      chk("rst_preadychk", 64'(preadychk0), 64'd1);
      chk("rst_pslverrchk", 64'(pslverrchk0), 64'd1);
`endif
      PRESETn = 1'b1;
      step();

      vecs.push_back('{0, 1'b0, 12'h004, 32'h0,        4'h0, 32'h0,        1'b0});
      vecs.push_back('{0, 1'b1, 12'h004, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0});
      vecs.push_back('{0, 1'b0, 12'h004, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
      vecs.push_back('{0, 1'b1, 12'h008, 32'h11223344, 4'hF, 32'h0,        1'b0});
      vecs.push_back('{0, 1'b1, 12'h008, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0});
      vecs.push_back('{0, 1'b0, 12'h008, 32'h0,        4'h0, 32'h11BB33DD, 1'b0});
      vecs.push_back('{0, 1'b1, 12'h00C, 32'h55555555, 4'h0, 32'h0,        1'b0});
      vecs.push_back('{0, 1'b0, 12'h00E, 32'h0,        4'h0, 32'h0,        1'b0});
      vecs.push_back('{0, 1'b0, 12'h040, 32'h0,        4'h0, 32'h0,        1'b1});
      vecs.push_back('{0, 1'b1, 12'h040, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1});
      vecs.push_back('{0, 1'b1, 12'h03F, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0});
      vecs.push_back('{0, 1'b0, 12'h03C, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0});
      vecs.push_back('{0, 1'b0, 12'hFFC, 32'h0,        4'h0, 32'h0,        1'b1});
      vecs.push_back('{1, 1'b0, 12'h000, 32'h0,        4'h0, 32'h0,        1'b0});
      vecs.push_back('{1, 1'b1, 12'h004, 32'h12345678, 4'hF, 32'h0,        1'b1});
      vecs.push_back('{1, 1'b0, 12'h004, 32'h0,        4'h0, 32'hA0000001, 1'b0});
      vecs.push_back('{1, 1'b1, 12'h000, 32'h0BADC0DE, 4'h3, 32'h0,        1'b0});
      vecs.push_back('{1, 1'b0, 12'h000, 32'h0,        4'h0, 32'h0000C0DE, 1'b0});
      vecs.push_back('{1, 1'b0, 12'h040, 32'h0,        4'h0, 32'h0,        1'b1});
      for (int v = 0; v < vecs.size(); v++)
         apb_xfer(vecs[v].dev, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].strb,
                  vecs[v].exp_rd, vecs[v].exp_err);

      chk("regout0_r1", 64'(reg_out0[1*DW +: DW]), 64'hDEADBEEF);
      chk("regout0_r2", 64'(reg_out0[2*DW +: DW]), 64'h11BB33DD);
      chk("regout0_r3", 64'(reg_out0[3*DW +: DW]), 64'h0);
      chk("regout0_r15", 64'(reg_out0[15*DW +: DW]), 64'hCAFEF00D);
      chk("regout1_r0", 64'(reg_out1[0*DW +: DW]), 64'h0000C0DE);
      chk("regout1_r1", 64'(reg_out1[1*DW +: DW]), 64'h0);

      // Back-to-back: the read's setup cycle is the cycle right after the write completes.
      psel0 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h010; PWDATA = 32'h01020304; PSTRB = 4'hF;
      step();
      PENABLE = 1'b1;
      chk("b2b_wr_ready", 64'(pready0), 64'd1);
      step();
      PENABLE = 1'b0; PWRITE = 1'b0;
      chk("b2b_ready_low", 64'(pready0), 64'd0);
      chk("b2b_reg4", 64'(reg_out0[4*DW +: DW]), 64'h01020304);
      step();
      PENABLE = 1'b1;
      chk("b2b_rd_ready", 64'(pready0), 64'd1);
      chk("b2b_rd_data", 64'(prdata0), 64'h01020304);
      step();
      psel0 = 1'b0; PENABLE = 1'b0;

      // Abort: the requester drops PSEL while the three-wait-state completer is still stalling.
      psel1 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h014; PWDATA = 32'h77777777; PSTRB = 4'hF;
      step();
      PENABLE = 1'b1;
      step();
      chk("abort_wait", 64'(pready1), 64'd0);
      psel1 = 1'b0; PENABLE = 1'b0;
      step();
      chk("abort_state", 64'(dbg1), 64'd0);
      chk("abort_ready", 64'(pready1), 64'd0);
      chk("abort_reg5", 64'(reg_out1[5*DW +: DW]), 64'h0);
      apb_xfer(1, 1'b0, 12'h014, 32'h0, 4'h0, 32'h0, 1'b0);
      apb_xfer(1, 1'b1, 12'h014, 32'h77777777, 4'hF, 32'h0, 1'b0);
      apb_xfer(1, 1'b0, 12'h014, 32'h0, 4'h0, 32'h77777777, 1'b0);

      // Reset pulse during the completion cycle of a write: the write must be lost.
      psel0 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h018; PWDATA = 32'h99999999; PSTRB = 4'hF;
      step();
      PENABLE = 1'b1;
      #2 PRESETn = 1'b0;
      #1;
      chk("mid_rst_ready", 64'(pready0), 64'd0);
      chk("mid_rst_prdata", 64'(prdata0), 64'd0);
      chk("mid_rst_pslverr", 64'(pslverr0), 64'd0);
      chk("mid_rst_state", 64'(dbg0), 64'd0);
      chk("mid_rst_regout0", 64'(|reg_out0), 64'd0);
      chk("mid_rst_regout1", 64'(|reg_out1), 64'd0);
      psel0 = 1'b0; PENABLE = 1'b0;
      step();
      PRESETn = 1'b1;
      step();
      chk("post_rst_reg6", 64'(reg_out0[6*DW +: DW]), 64'h0);

      for (int i = 0; i < NR; i++) m0[i] = 32'h0;
      for (int n = 0; n < 10; n++) begin
         ridx = $urandom_range(8, 11);
         rd   = $urandom;
         rs   = 4'($urandom_range(0, 15));
         apb_xfer(0, 1'b1, 12'(ridx * 4), rd, rs, 32'h0, 1'b0);
         for (int k = 0; k < 4; k++)
            if (rs[k]) m0[ridx][k*8 +: 8] = rd[k*8 +: 8];
         apb_xfer(0, 1'b0, 12'(ridx * 4 + $urandom_range(0, 3)), 32'h0, 4'h0, m0[ridx], 1'b0);
      end

`ifdef APB_PARITY_EN
      flip_wchk = 1'b1;
      psel0 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h030; PWDATA = 32'h12345678; PSTRB = 4'hF;
      step();
      PENABLE = 1'b1;
      chk("par_ready", 64'(pready0), 64'd1);
      chk("par_pslverr", 64'(pslverr0), 64'd1);
      chk("par_pslverrchk", 64'(pslverrchk0), 64'd0);
      chk("par_err_pulse", 64'(parity_err0), 64'd1);
      step();
      flip_wchk = 1'b0;
      psel0 = 1'b0; PENABLE = 1'b0;
      chk("par_err_end", 64'(parity_err0), 64'd0);
      chk("par_reg12", 64'(reg_out0[12*DW +: DW]), 64'h0);
      apb_xfer(0, 1'b1, 12'h034, 32'h0000FFFF, 4'hF, 32'h0, 1'b0);
      psel0 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 12'h034;
      step();
      PENABLE = 1'b1;
      chk("par_rd_data", 64'(prdata0), 64'h0000FFFF);
      chk("par_prdatachk", 64'(prdatachk0), 64'hF);
      chk("par_preadychk", 64'(preadychk0), 64'd0);
      step();
      psel0 = 1'b0; PENABLE = 1'b0;
`endif

      chk("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
